frag_buf_ctrl: RTL and testbench

Sequencing controller for the data-fragmentation buffer in the TL TX path. It accepts one TLP at a time from the TX arbiter and admits up to 9 four-DW locations per beat into the buffer without overflow. It issues 1- or 2-location reads toward the fragmenter and hands off to the next TLP only after the buffer reports completion on `start_fragment`.

---
 rtl/frag_buf_ctrl.sv | 167 ++++++++++++++++
 tb/tb_frag_buf_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frag_buf_ctrl.sv
// frag_buf_ctrl: sequencing controller for the TL TX data-fragmentation buffer.
// It takes one TLP at a time and admits beats of 1..9 four-DW locations
// without overflowing the buffer. It drains with 1- or 2-location reads,
// then waits for the buffer's start_fragment pulse before taking the next TLP.
module frag_buf_ctrl #(
  parameter int BUF_DEPTH = 32,
  parameter int CNT_W     = 6,
  parameter int LEN_W     = 10
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             tlp_valid,
  input  logic [LEN_W-1:0] tlp_len_loc,
  output logic             tlp_ready,
  input  logic             beat_valid,
  input  logic [3:0]       beat_loc,
  output logic             beat_ready,
  output logic             buf_wr_en,
  output logic [3:0]       buf_no_loc_wr,
  output logic             buf_rd_en,
  output logic             buf_rd_mode,
  input  logic             buf_start_fragment,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             out_mode,
  output logic             tlp_done,
  output logic             err_beat,
  output logic [CNT_W-1:0] occupancy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W+1)'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_N = CNT_W'(BUF_DEPTH);

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_wr_rem, w_wr_rem_nxt;
  logic [LEN_W-1:0] r_rd_rem, w_rd_rem_nxt;
  logic [CNT_W-1:0] r_occ, w_occ_nxt;
  logic             r_out_valid, r_out_mode;

  logic [LEN_W-1:0] w_beat_ext;
  logic [CNT_W:0]   w_fill;
  logic             w_fits;
  logic             w_loc_legal;
  logic [3:0]       w_wr_loc;
  logic [1:0]       w_rd_loc;

  // Occupancy update at one extra bit; the result is clamped to the buffer
  // depth so a corrupted count can never wrap into a small value.
  function automatic logic [CNT_W-1:0] occ_update(input logic [CNT_W-1:0] occ,
                                                  input logic [3:0]       wr,
                                                  input logic [1:0]       rd);
    logic [CNT_W:0] v;
    v = {1'b0, occ} + (CNT_W+1)'(wr) - (CNT_W+1)'(rd);
    if (v > DEPTH_W) return DEPTH_N;
    return v[CNT_W-1:0];
  endfunction

  assign w_beat_ext  = LEN_W'(beat_loc);
  // Full check uses the current occupancy only; a read issued in the same
  // cycle does not make room for this beat.
  assign w_fill      = {1'b0, r_occ} + (CNT_W+1)'(beat_loc);
  assign w_fits      = (w_fill <= DEPTH_W);
  assign w_loc_legal = (beat_loc != 4'd0) && (beat_loc <= 4'd9) &&
                       (w_beat_ext <= r_wr_rem);

  // Next-state logic and combinational buffer controls
  always_comb begin
    w_state_nxt   = r_state;
    w_wr_rem_nxt  = r_wr_rem;
    w_rd_rem_nxt  = r_rd_rem;
    tlp_ready     = 1'b0;
    beat_ready    = 1'b0;
    buf_wr_en     = 1'b0;
    buf_no_loc_wr = 4'd0;
    buf_rd_en     = 1'b0;
    buf_rd_mode   = 1'b0;
    tlp_done      = 1'b0;
    err_beat      = 1'b0;
    w_wr_loc      = 4'd0;
    w_rd_loc      = 2'd0;
    case (r_state)
      S_IDLE: begin
        tlp_ready = 1'b1;
        if (tlp_valid) begin
          if (tlp_len_loc != '0) begin
            w_wr_rem_nxt = tlp_len_loc;
            w_rd_rem_nxt = tlp_len_loc;
            w_state_nxt  = S_XFER;
          end else begin
            err_beat = 1'b1;
          end
        end
      end
      S_XFER: begin
        beat_ready = beat_valid && (r_wr_rem != '0) && w_fits;
        if (beat_ready) begin
          if (w_loc_legal) begin
            buf_wr_en     = 1'b1;
            buf_no_loc_wr = beat_loc;
            w_wr_loc      = beat_loc;
            w_wr_rem_nxt  = r_wr_rem - w_beat_ext;
          end else begin
            err_beat = 1'b1;
          end
        end
        // A single-location read is reserved for the odd tail of the TLP
        if (out_ready) begin
          if ((r_rd_rem >= LEN_W'(2)) && (r_occ >= CNT_W'(2))) begin
            buf_rd_en    = 1'b1;
            buf_rd_mode  = 1'b1;
            w_rd_loc     = 2'd2;
            w_rd_rem_nxt = r_rd_rem - LEN_W'(2);
          end else if ((r_rd_rem == LEN_W'(1)) && (r_occ >= CNT_W'(1))) begin
            buf_rd_en    = 1'b1;
            buf_rd_mode  = 1'b0;
            w_rd_loc     = 2'd1;
            w_rd_rem_nxt = '0;
          end
        end
        if (buf_rd_en && (w_rd_rem_nxt == '0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (buf_start_fragment) begin
          tlp_done    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_occ_nxt = occ_update(r_occ, w_wr_loc, w_rd_loc);

  // State, remaining counters, occupancy and registered read-valid tracking
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state     <= S_IDLE;
      r_wr_rem    <= '0;
      r_rd_rem    <= '0;
      r_occ       <= '0;
      r_out_valid <= 1'b0;
      r_out_mode  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_rem    <= w_wr_rem_nxt;
      r_rd_rem    <= w_rd_rem_nxt;
      r_occ       <= w_occ_nxt;
      r_out_valid <= buf_rd_en;
      r_out_mode  <= buf_rd_mode;
    end
  end

  assign occupancy = r_occ;
  assign out_valid = r_out_valid;
  assign out_mode  = r_out_mode;

endmodule

// File: tb/tb_frag_buf_ctrl.sv
// Self-checking bench for frag_buf_ctrl: per-cycle vector table plus
// hand-written sequences for buffer stall and mid-TLP reset.
module tb_frag_buf_ctrl;

  localparam int BUF_DEPTH = 32;
  localparam int CNT_W     = 6;
  localparam int LEN_W     = 10;

  logic             clk = 1'b0;
  logic             arst;
  logic             tlp_valid;
  logic [LEN_W-1:0] tlp_len_loc;
  logic             tlp_ready;
  logic             beat_valid;
  logic [3:0]       beat_loc;
  logic             beat_ready;
  logic             buf_wr_en;
  logic [3:0]       buf_no_loc_wr;
  logic             buf_rd_en;
  logic             buf_rd_mode;
  logic             buf_start_fragment;
  logic             out_ready;
  logic             out_valid;
  logic             out_mode;
  logic             tlp_done;
  logic             err_beat;
  logic [CNT_W-1:0] occupancy;

  frag_buf_ctrl #(.BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk                (clk),
    .arst               (arst),
    .tlp_valid          (tlp_valid),
    .tlp_len_loc        (tlp_len_loc),
    .tlp_ready          (tlp_ready),
    .beat_valid         (beat_valid),
    .beat_loc           (beat_loc),
    .beat_ready         (beat_ready),
    .buf_wr_en          (buf_wr_en),
    .buf_no_loc_wr      (buf_no_loc_wr),
    .buf_rd_en          (buf_rd_en),
    .buf_rd_mode        (buf_rd_mode),
    .buf_start_fragment (buf_start_fragment),
    .out_ready          (out_ready),
    .out_valid          (out_valid),
    .out_mode           (out_mode),
    .tlp_done           (tlp_done),
    .err_beat           (err_beat),
    .occupancy          (occupancy)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus and the full expected output picture, packed as
  // {tlp_ready, beat_ready, wr_en, no_loc_wr[3:0], rd_en, rd_mode,
  //  out_valid, out_mode, tlp_done, err_beat, occupancy[5:0]}
  typedef struct {
    logic             tv;
    logic [LEN_W-1:0] tlen;
    logic             bv;
    logic [3:0]       bloc;
    logic             ordy;
    logic             sf;
    logic [18:0]      exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rd_locs = 0;

  function automatic logic [18:0] ex(input int tr, input int br, input int we,
                                     input int nl, input int re, input int rm,
                                     input int ov, input int om, input int td,
                                     input int eb, input int occ);
    return {1'(tr), 1'(br), 1'(we), 4'(nl), 1'(re), 1'(rm),
            1'(ov), 1'(om), 1'(td), 1'(eb), 6'(occ)};
  endfunction

  function automatic logic [18:0] act_vec();
    return {tlp_ready, beat_ready, buf_wr_en, buf_no_loc_wr, buf_rd_en,
            buf_rd_mode, out_valid, out_mode, tlp_done, err_beat, occupancy};
  endfunction

  task automatic add(input int tv, input int tlen, input int bv, input int bloc,
                     input int ordy, input int sf, input logic [18:0] e);
    vec_t v;
    v.tv   = 1'(tv);
    v.tlen = LEN_W'(tlen);
    v.bv   = 1'(bv);
    v.bloc = 4'(bloc);
    v.ordy = 1'(ordy);
    v.sf   = 1'(sf);
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Observe the current cycle away from the active edge, tallying reads
  task automatic sample();
    @(negedge clk);
    if (buf_rd_en) rd_locs += (buf_rd_mode ? 2 : 1);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Drain the current TLP and walk through the completion handshake
  task automatic finish_tlp(input string tag, input int target);
    out_ready  = 1'b1;
    beat_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sample();
      if (rd_locs >= target) break;
      advance();
    end
    check({tag, "_reads"}, 32'(rd_locs), 32'(target));
    advance();
    sample();
    check({tag, "_no_early_done"}, 32'(tlp_done), 32'(0));
    advance();
    buf_start_fragment = 1'b1;
    sample();
    check({tag, "_tlp_done"}, 32'(tlp_done), 32'(1));
    advance();
    buf_start_fragment = 1'b0;
    sample();
    check({tag, "_tlp_ready"}, 32'(tlp_ready), 32'(1));
    advance();
  endtask

  task automatic start_tlp(input int len);
    tlp_valid   = 1'b1;
    tlp_len_loc = LEN_W'(len);
    rd_locs     = 0;
    sample();
    check("accept_ready", 32'(tlp_ready), 32'(1));
    advance();
    tlp_valid   = 1'b0;
    tlp_len_loc = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] rst_exp;
    int          hold;
    bit          acc;

    rst_exp = ex(1,0,0,0,0,0,0,0,0,0,0);

    // Single-beat TLP of 9 locations
    add(1,9,0,0,1,0, ex(1,0,0,0,0,0,0,0,0,0,0));
    add(0,0,1,9,1,0, ex(0,1,1,9,0,0,0,0,0,0,0));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,1,0,0,0,0,9));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,1,1,1,0,0,7));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,1,1,1,0,0,5));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,1,1,1,0,0,3));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,0,1,1,0,0,1));
    add(0,0,0,0,1,0, ex(0,0,0,0,0,0,1,0,0,0,0));
    add(0,0,0,0,1,1, ex(0,0,0,0,0,0,0,0,1,0,0));
    add(0,0,0,0,0,0, ex(1,0,0,0,0,0,0,0,0,0,0));
    // Zero-length TLP is rejected in IDLE
    add(1,0,0,0,0,0, ex(1,0,0,0,0,0,0,0,0,1,0));
    add(0,0,0,0,0,0, ex(1,0,0,0,0,0,0,0,0,0,0));
    // Odd tail: 3 locations
    add(1,3,0,0,1,0, ex(1,0,0,0,0,0,0,0,0,0,0));
    add(0,0,1,3,1,0, ex(0,1,1,3,0,0,0,0,0,0,0));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,1,0,0,0,0,3));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,0,1,1,0,0,1));
    add(0,0,0,0,1,0, ex(0,0,0,0,0,0,1,0,0,0,0));
    add(0,0,0,0,1,1, ex(0,0,0,0,0,0,0,0,1,0,0));
    add(0,0,0,0,0,0, ex(1,0,0,0,0,0,0,0,0,0,0));
    // Illegal beat (7 > remaining 5) then a legal beat of 5
    add(1,5,0,0,0,0, ex(1,0,0,0,0,0,0,0,0,0,0));
    add(0,0,1,7,0,0, ex(0,1,0,0,0,0,0,0,0,1,0));
    add(0,0,1,5,0,0, ex(0,1,1,5,0,0,0,0,0,0,0));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,1,0,0,0,0,5));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,1,1,1,0,0,3));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,0,1,1,0,0,1));
    add(0,0,0,0,1,0, ex(0,0,0,0,0,0,1,0,0,0,0));
    add(0,0,0,0,1,1, ex(0,0,0,0,0,0,0,0,1,0,0));
    add(0,0,0,0,0,0, ex(1,0,0,0,0,0,0,0,0,0,0));
    // Concurrent write and read at occupancy 4; beat offered in IDLE is not taken
    add(1,7,1,4,0,0, ex(1,0,0,0,0,0,0,0,0,0,0));
    add(0,0,1,4,0,0, ex(0,1,1,4,0,0,0,0,0,0,0));
    add(0,0,1,3,1,0, ex(0,1,1,3,1,1,0,0,0,0,4));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,1,1,1,0,0,5));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,1,1,1,0,0,3));
    add(0,0,0,0,1,0, ex(0,0,0,0,1,0,1,1,0,0,1));
    add(0,0,0,0,1,0, ex(0,0,0,0,0,0,1,0,0,0,0));
    add(0,0,0,0,1,1, ex(0,0,0,0,0,0,0,0,1,0,0));
    add(0,0,0,0,0,0, ex(1,0,0,0,0,0,0,0,0,0,0));

    arst               = 1'b0;
    tlp_valid          = 1'b0;
    tlp_len_loc        = '0;
    beat_valid         = 1'b0;
    beat_loc           = 4'd0;
    out_ready          = 1'b0;
    buf_start_fragment = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    arst = 1'b1;
    sample();
    check("reset_state", 32'(act_vec()), 32'(rst_exp));
    advance();

    foreach (vecs[i]) begin
      tlp_valid          = vecs[i].tv;
      tlp_len_loc        = vecs[i].tlen;
      beat_valid         = vecs[i].bv;
      beat_loc           = vecs[i].bloc;
      out_ready          = vecs[i].ordy;
      buf_start_fragment = vecs[i].sf;
      sample();
      check($sformatf("vec%0d", i), 32'(act_vec()), 32'(vecs[i].exp));
      advance();
    end
    tlp_valid = 1'b0; beat_valid = 1'b0; out_ready = 1'b0; buf_start_fragment = 1'b0;

    // Full stall: 40 locations in beats of 9 with the fragmenter not ready
    start_tlp(40);
    for (int i = 0; i < 3; i++) begin
      beat_valid = 1'b1;
      beat_loc   = 4'd9;
      sample();
      check($sformatf("stall_beat%0d_ready", i), 32'(beat_ready), 32'(1));
      check($sformatf("stall_beat%0d_occ", i), 32'(occupancy), 32'(9*i));
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      sample();
      check("stall_held_ready", 32'(beat_ready), 32'(0));
      check("stall_held_occ", 32'(occupancy), 32'(27));
      advance();
    end
    out_ready = 1'b1;
    acc  = 1'b0;
    hold = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (beat_ready) begin
        acc  = 1'b1;
        hold = i;
        check("stall_release_occ", 32'(occupancy), 32'(23));
        break;
      end
      advance();
    end
    check("stall_release_seen", 32'(acc), 32'(1));
    check("stall_release_wait", 32'(hold), 32'(2));
    advance();
    beat_loc = 4'd4;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (beat_ready) begin
        acc = 1'b1;
        check("stall_tail_wr", 32'({buf_wr_en, buf_no_loc_wr}), 32'({1'b1, 4'd4}));
        break;
      end
      advance();
    end
    check("stall_tail_seen", 32'(acc), 32'(1));
    advance();
    beat_valid = 1'b0;
    finish_tlp("stall", 40);

    // Reset in the middle of a TLP with 12 locations held
    out_ready = 1'b0;
    start_tlp(20);
    beat_valid = 1'b1;
    beat_loc   = 4'd9;
    sample();
    advance();
    beat_loc = 4'd3;
    sample();
    advance();
    beat_loc = 4'd9;
    sample();
    check("rst_pre_occ", 32'(occupancy), 32'(12));
    arst = 1'b0;
    #1;
    check("rst_mid_outputs", 32'(act_vec()), 32'(rst_exp));
    @(posedge clk);
    #1;
    check("rst_held_outputs", 32'(act_vec()), 32'(rst_exp));
    arst       = 1'b1;
    beat_valid = 1'b0;
    start_tlp(3);
    beat_valid = 1'b1;
    beat_loc   = 4'd3;
    sample();
    check("rst_after_wr", 32'({beat_ready, buf_wr_en, occupancy}),
          32'({1'b1, 1'b1, 6'd0}));
    advance();
    finish_tlp("post_rst", 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
